// File: rtl/imem_ctrl_pkg.sv
// imem_ctrl_pkg: shared FSM encoding and default configuration for the instruction-memory responder
package imem_ctrl_pkg;
   localparam int          DEF_ADDR_WIDTH     = 32;
   localparam int          DEF_INSTR_WIDTH    = 32;
   localparam bit          DEF_HAS_ITCM       = 1'b1;
   localparam logic [31:0] DEF_ITCM_BASE      = 32'h0000_0000;
   localparam int          DEF_ITCM_SIZE_LOG2 = 16;
   typedef enum logic [1:0] {IDLE, ITCM_RD, BUS_REQ, BUS_WAIT} imem_state_e;
endpackage

// File: rtl/imem_line_buf.sv
// imem_line_buf: single tagged instruction entry with fill, invalidate and lookup
module imem_line_buf
   import imem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inv,
   input  logic                   fill,
   input  logic [ADDR_WIDTH-1:0]  fill_tag,
   input  logic [INSTR_WIDTH-1:0] fill_data,
   input  logic                   fill_err,
   input  logic [ADDR_WIDTH-1:0]  pc,
   output logic                   hit,
   output logic [INSTR_WIDTH-1:0] data,
   output logic                   err
);
   logic                  buf_v;
   logic [ADDR_WIDTH-1:0] buf_tag;

   // invalidate wins over fill; the controller never fills while invalidating
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_v   <= 1'b0;
         buf_tag <= '0;
         data    <= '0;
         err     <= 1'b0;
      end else if (inv) begin
         buf_v <= 1'b0;
      end else if (fill) begin
         buf_v   <= 1'b1;
         buf_tag <= fill_tag;
         data    <= fill_data;
         err     <= fill_err;
      end
   end

   assign hit = buf_v && buf_tag == pc;
endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: IF-stage responder serving ITCM or the instruction bus behind a 1-entry buffer
module imem_ctrl
   import imem_ctrl_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int                    INSTR_WIDTH    = DEF_INSTR_WIDTH,
   parameter bit                    HAS_ITCM       = DEF_HAS_ITCM,
   parameter logic [ADDR_WIDTH-1:0] ITCM_BASE      = DEF_ITCM_BASE,
   parameter int                    ITCM_SIZE_LOG2 = DEF_ITCM_SIZE_LOG2
) (
   input  logic                      cpu_clk,
   input  logic                      cpu_rst,
   input  logic [ADDR_WIDTH-1:0]     pc,
   input  logic                      imem_inv,
   output logic                      instr_read_data_valid,
   output logic [INSTR_WIDTH-1:0]    instr_read_data,
   output logic                      instr_fetch_err,
   output logic                      itcm_cs,
   output logic [ITCM_SIZE_LOG2-3:0] itcm_addr,
   input  logic [INSTR_WIDTH-1:0]    itcm_rdata,
   output logic                      ibus_req,
   output logic [ADDR_WIDTH-1:0]     ibus_addr,
   input  logic                      ibus_gnt,
   input  logic                      ibus_rvalid,
   input  logic [INSTR_WIDTH-1:0]    ibus_rdata,
   input  logic                      ibus_err
);
   imem_state_e             state, nxt;
   logic [ADDR_WIDTH-1:0]   req_tag;
   logic                    drop, load, fill, hit, buf_err, fill_err, keep, fwd, in_itcm, misal;
   logic [INSTR_WIDTH-1:0]  buf_data, fill_data;

   assign in_itcm   = HAS_ITCM && pc[ADDR_WIDTH-1:ITCM_SIZE_LOG2] == ITCM_BASE[ADDR_WIDTH-1:ITCM_SIZE_LOG2];
   assign misal     = |pc[1:0];
   assign keep      = !drop && !imem_inv;
   assign fwd       = keep && req_tag == pc;
   assign fill_err  = state == BUS_WAIT && ibus_err;
   assign fill_data = state == BUS_WAIT ? (ibus_err ? '0 : ibus_rdata) : itcm_rdata;

   imem_line_buf #(.ADDR_WIDTH(ADDR_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) u_buf (
      .clk       (cpu_clk),
      .rst       (cpu_rst),
      .inv       (imem_inv),
      .fill      (fill),
      .fill_tag  (req_tag),
      .fill_data (fill_data),
      .fill_err  (fill_err),
      .pc        (pc),
      .hit       (hit),
      .data      (buf_data),
      .err       (buf_err)
   );

   // state, captured request tag and the drop flag for invalidated in-flight responses
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state   <= IDLE;
         req_tag <= '0;
         drop    <= 1'b0;
      end else begin
         state   <= nxt;
         req_tag <= load ? pc : req_tag;
         drop    <= nxt != IDLE && (drop || (imem_inv && state != IDLE));
      end
   end

   // next state, memory strobes and response/bypass muxing; reset forces every output low
   always_comb begin
      nxt                   = state;
      load                  = 1'b0;
      fill                  = 1'b0;
      instr_read_data_valid = 1'b0;
      instr_read_data       = '0;
      instr_fetch_err       = 1'b0;
      itcm_cs               = 1'b0;
      itcm_addr             = '0;
      ibus_req              = 1'b0;
      ibus_addr             = '0;
      case (state)
         IDLE: begin
            if (hit && !imem_inv) begin
               instr_read_data_valid = 1'b1;
               instr_read_data       = buf_data;
               instr_fetch_err       = buf_err;
            end else if (!misal && in_itcm) begin
               itcm_cs   = 1'b1;
               itcm_addr = pc[ITCM_SIZE_LOG2-1:2];
               load      = 1'b1;
               nxt       = ITCM_RD;
            end else if (!misal) begin
               ibus_req  = 1'b1;
               ibus_addr = pc;
               load      = 1'b1;
               nxt       = ibus_gnt ? BUS_WAIT : BUS_REQ;
            end
         end
         ITCM_RD: begin
            fill                  = keep;
            instr_read_data_valid = fwd;
            instr_read_data       = fwd ? itcm_rdata : '0;
            nxt                   = IDLE;
         end
         BUS_REQ: begin
            ibus_req  = 1'b1;
            ibus_addr = req_tag;
            nxt       = ibus_gnt ? BUS_WAIT : BUS_REQ;
         end
         BUS_WAIT: begin
            if (ibus_rvalid) begin
               fill                  = keep;
               instr_read_data_valid = fwd;
               instr_fetch_err       = fwd && ibus_err;
               instr_read_data       = (fwd && !ibus_err) ? ibus_rdata : '0;
               nxt                   = IDLE;
            end
         end
         default: nxt = IDLE;
      endcase
      if (cpu_rst) begin
         load                  = 1'b0;
         fill                  = 1'b0;
         instr_read_data_valid = 1'b0;
         instr_read_data       = '0;
         instr_fetch_err       = 1'b0;
         itcm_cs               = 1'b0;
         itcm_addr             = '0;
         ibus_req              = 1'b0;
         ibus_addr             = '0;
      end
   end
endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: directed checks of ITCM, bus, pc change, invalidate, error and reset behaviour
module tb_imem_ctrl;
   logic        cpu_clk = 1'b0;
   logic        cpu_rst, imem_inv, valid, ferr, cs, req, gnt, rvalid, berr;
   logic [31:0] pc, data, irdata, baddr, rdata;
   logic [13:0] iaddr;
   int          total = 0;
   int          bad = 0;

   imem_ctrl dut (
      .cpu_clk               (cpu_clk),
      .cpu_rst               (cpu_rst),
      .pc                    (pc),
      .imem_inv              (imem_inv),
      .instr_read_data_valid (valid),
      .instr_read_data       (data),
      .instr_fetch_err       (ferr),
      .itcm_cs               (cs),
      .itcm_addr             (iaddr),
      .itcm_rdata            (irdata),
      .ibus_req              (req),
      .ibus_addr             (baddr),
      .ibus_gnt              (gnt),
      .ibus_rvalid           (rvalid),
      .ibus_rdata            (rdata),
      .ibus_err              (berr)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   initial begin
      cpu_rst = 1'b1; pc = 32'h100; imem_inv = 1'b0; irdata = 32'h0000_8067;
      gnt = 1'b0; rvalid = 1'b0; rdata = '0; berr = 1'b0;
      tick(); tick();
      settle();
      chk("rst_valid", valid, 0);
      chk("rst_data", data, 0);
      chk("rst_cs", cs, 0);
      chk("rst_iaddr", 32'(iaddr), 0);
      chk("rst_req", req, 0);
      chk("rst_baddr", baddr, 0);
      tick();
      cpu_rst = 1'b0;
      settle();
      chk("itcm_cs0", cs, 1);
      chk("itcm_addr0", 32'(iaddr), 32'h40);
      chk("itcm_valid0", valid, 0);
      tick(); settle();
      chk("itcm_valid1", valid, 1);
      chk("itcm_data1", data, 32'h0000_8067);
      chk("itcm_cs1", cs, 0);
      tick(); settle();
      chk("itcm_hold_valid", valid, 1);
      chk("itcm_hold_data", data, 32'h0000_8067);
      chk("itcm_hold_cs", cs, 0);
      tick();
      pc = 32'h102;
      settle();
      chk("misal_cs", cs, 0);
      chk("misal_req", req, 0);
      chk("misal_valid", valid, 0);
      tick();
      pc = 32'h8000_0000;
      settle();
      chk("bus_req0", req, 1);
      chk("bus_addr0", baddr, 32'h8000_0000);
      chk("bus_valid0", valid, 0);
      tick();
      gnt = 1'b1;
      settle();
      chk("bus_req1", req, 1);
      chk("bus_addr1", baddr, 32'h8000_0000);
      tick();
      gnt = 1'b0;
      settle();
      chk("bus_wait_req", req, 0);
      chk("bus_wait_valid0", valid, 0);
      tick(); settle();
      chk("bus_wait_valid1", valid, 0);
      tick();
      rvalid = 1'b1; rdata = 32'h13;
      settle();
      chk("bus_rvalid_valid", valid, 1);
      chk("bus_rvalid_data", data, 32'h13);
      chk("bus_rvalid_err", ferr, 0);
      tick();
      rvalid = 1'b0; rdata = '0;
      settle();
      chk("bus_hold_valid", valid, 1);
      chk("bus_hold_data", data, 32'h13);
      chk("bus_hold_req", req, 0);
      tick();
      pc = 32'h8000_0100; gnt = 1'b1;
      settle();
      chk("chg_req", req, 1);
      chk("chg_addr", baddr, 32'h8000_0100);
      tick();
      gnt = 1'b0; pc = 32'h8000_0110;
      settle();
      chk("chg_wait_req", req, 0);
      tick();
      rvalid = 1'b1; rdata = 32'h1111;
      settle();
      chk("chg_no_fwd", valid, 0);
      tick();
      rvalid = 1'b0;
      settle();
      chk("chg_newreq", req, 1);
      chk("chg_newaddr", baddr, 32'h8000_0110);
      pc = 32'h8000_0100;
      settle();
      chk("chg_tag_hit", valid, 1);
      chk("chg_tag_data", data, 32'h1111);
      chk("chg_tag_noreq", req, 0);
      tick();
      pc = 32'h8000_0110; gnt = 1'b1;
      settle();
      chk("inv_req", req, 1);
      tick();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h2222; imem_inv = 1'b1;
      settle();
      chk("inv_rsp_valid", valid, 0);
      chk("inv_rsp_data", data, 0);
      tick();
      rvalid = 1'b0; imem_inv = 1'b0; gnt = 1'b1;
      settle();
      chk("inv_refetch_req", req, 1);
      chk("inv_refetch_valid", valid, 0);
      tick();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h3333;
      settle();
      chk("refetch_valid", valid, 1);
      chk("refetch_data", data, 32'h3333);
      tick();
      rvalid = 1'b0;
      settle();
      chk("hit_before_inv", valid, 1);
      imem_inv = 1'b1;
      settle();
      chk("hit_inv_valid", valid, 0);
      chk("hit_inv_data", data, 0);
      tick();
      imem_inv = 1'b0;
      settle();
      chk("after_inv_req", req, 1);
      chk("after_inv_valid", valid, 0);
      gnt = 1'b1;
      tick();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'hdead_beef; berr = 1'b1;
      settle();
      chk("err_valid", valid, 1);
      chk("err_err", ferr, 1);
      chk("err_data", data, 0);
      tick();
      rvalid = 1'b0; berr = 1'b0; rdata = '0;
      settle();
      chk("err_hold_err", ferr, 1);
      chk("err_hold_data", data, 0);
      tick();
      pc = 32'h8000_0200; gnt = 1'b1;
      settle();
      chk("rst_txn_req", req, 1);
      tick();
      gnt = 1'b0; cpu_rst = 1'b1;
      settle();
      chk("rst_mid_req", req, 0);
      tick();
      cpu_rst = 1'b0; pc = 32'h102; rvalid = 1'b1; rdata = 32'h5555;
      settle();
      chk("orphan_valid", valid, 0);
      chk("orphan_data", data, 0);
      chk("orphan_req", req, 0);
      chk("orphan_cs", cs, 0);
      chk("orphan_baddr", baddr, 0);
      tick();
      rvalid = 1'b0; pc = 32'h8000_0200;
      settle();
      chk("post_rst_req", req, 1);
      chk("post_rst_addr", baddr, 32'h8000_0200);
      chk("post_rst_valid", valid, 0);
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
